// File: rtl/wb_write_queue.sv
// In-order writeback queue in front of the register file write port.
// It drains one entry per cycle and forwards queued data to the decode read ports.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_reg,
  input  logic [31:0]   in_data,
  input  logic          wb_stall,
  output logic [4:0]    W_reg,
  output logic [31:0]   W_data,
  output logic          W_en,
  input  logic [4:0]    R_reg_1,
  input  logic [4:0]    R_reg_2,
  output logic          fwd_hit_1,
  output logic [31:0]   fwd_data_1,
  output logic          fwd_hit_2,
  output logic [31:0]   fwd_data_2,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    r_regs [DEPTH];
  logic [31:0]   r_vals [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_deq;
  logic          w_push;
  logic [AW-1:0] w_idx;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_deq    = (r_count != '0) && !wb_stall;
  assign in_ready = !w_full || w_deq;
  // Writes to x0 complete the handshake but are never stored.
  assign w_push   = in_valid && in_ready && (in_reg != 5'd0);

  assign W_en   = w_deq;
  assign W_reg  = w_deq ? r_regs[r_head] : 5'd0;
  assign W_data = w_deq ? r_vals[r_head] : 32'd0;
  assign count  = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) begin
        r_head <= r_head + AW'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      case ({w_push, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_regs[r_tail] <= in_reg;
      r_vals[r_tail] <= in_data;
    end
  end

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_data_1 = 32'd0;
    fwd_hit_2  = 1'b0;
    fwd_data_2 = 32'd0;
    w_idx      = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if (CW'(i) < r_count) begin
        if ((R_reg_1 != 5'd0) && (r_regs[w_idx] == R_reg_1)) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = r_vals[w_idx];
        end
        if ((R_reg_2 != 5'd0) && (r_regs[w_idx] == R_reg_2)) begin
          fwd_hit_2  = 1'b1;
          fwd_data_2 = r_vals[w_idx];
        end
      end
    end
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writer-side front end for the CPU register file's single write port.
- Buffers register writeback results from the execute/memory side in a small in-order FIFO and drains one entry per cycle onto the register file write interface (W_reg/W_data/W_en).
- Snoops the decode-stage read addresses and forwards data for writes that are still queued, so reads stay coherent with the register file.

Parameters:
DEPTH, 4, number of queued writes; power of two, minimum 2
CW, 3, count width; equals log2(DEPTH)+1

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low; clears all state
in_valid  input  1  producer presents a writeback result
in_ready  output  1  queue can accept this cycle
in_reg  input  5  destination register index
in_data  input  32  result value
wb_stall  input  1  holds the write port idle (debug/freeze); no drain while high
W_reg  output  5  register file write index
W_data  output  32  register file write data
W_en  output  1  register file write enable
R_reg_1  input  5  decode read address 1 (snoop)
R_reg_2  input  5  decode read address 2 (snoop)
fwd_hit_1  output  1  a queued write targets R_reg_1
fwd_data_1  output  32  data of the youngest queued write to R_reg_1
fwd_hit_2  output  1  a queued write targets R_reg_2
fwd_data_2  output  32  data of the youngest queued write to R_reg_2
count  output  CW  number of valid entries

Behaviour:
- Storage: DEPTH entries of {reg[4:0], data[31:0]}, circular head/tail pointers, plus count.
- Reset (reset low, asynchronous): head = tail = count = 0. Outputs: W_en = 0, W_reg = 0, W_data = 0, in_ready = 1, fwd_hit_1/2 = 0, fwd_data_1/2 = 0. Entry contents are don't-care.
- Drain (deq): deq = (count != 0) && !wb_stall.
  - W_en = deq; W_reg/W_data = head entry, combinational from registers.
  - When W_en = 0, W_reg and W_data drive 0.
  - Head advances at the posedge where deq = 1.
- Accept: in_ready = (count != DEPTH) || deq. This allows simultaneous push and pop when full.
  - Push at posedge when in_valid && in_ready && in_reg != 0; tail advances.
  - in_valid && in_ready && in_reg == 0: handshake completes, nothing stored (x0 writes discarded).
- Count update:
  - push only: +1
  - deq only: -1
  - push and deq: unchanged
  - Count never exceeds DEPTH and never underflows.
- Latency: an entry pushed at edge N is presented on W_* from cycle N+1 when the queue was empty and wb_stall is low.
- Ordering: strictly FIFO; writes reach the register file in acceptance order.
- Forwarding (combinational), per read port k:
  - fwd_hit_k = 1 iff R_reg_k != 0 and any valid entry, including the head currently being written, has reg == R_reg_k.
  - fwd_data_k = data of the youngest (closest to tail) matching entry; 0 when no hit.
  - The head is included because the register file commits only at the next edge.
  - The in_* input of the current cycle is not forwarded.
- Pointer wrap: head and tail wrap modulo DEPTH. Full/empty is decided by count, not by pointer equality.
- wb_stall high: W_en = 0, no drain. Pushes continue until full, then in_ready = 0. Forwarding remains active.
- Reset mid-operation: all queued writes are dropped immediately; no W_en pulse is issued for them.

Test Plan:
- Reset release, then push (in_reg=5, in_data=0x1234) -> next cycle W_en=1, W_reg=5, W_data=0x1234, count=1; the following cycle W_en=0, count=0.
- wb_stall=1; push regs 1,2,3,4 with data 0xA1..0xA4 -> count=4, in_ready=0, W_en=0. Drop wb_stall -> W_en for 4 consecutive cycles in order 1,2,3,4.
- Full queue with wb_stall=0 and in_valid=1 (reg 6, data 0xB6) -> in_ready=1, count stays 4; reg 6 is written after the 4 older entries; pointers wrap correctly.
- Stalled queue holding reg7=0x11 then reg7=0x22; R_reg_1=7, R_reg_2=0 -> fwd_hit_1=1, fwd_data_1=0x22, fwd_hit_2=0, fwd_data_2=0.
- Push in_reg=0, in_data=0xFFFF -> handshake accepted, count unchanged, no W_en.
- 3 entries queued under stall; assert reset low asynchronously between edges -> count=0, W_en=0, in_ready=1 immediately; no stale write after reset release.
